savestate_stream: RTL and testbench

SAVESTATE_STREAM -- requirements
Module: savestate_stream

---
 rtl/savestate_stream.sv | 229 ++++++++++++++++++++++
 tb/tb_savestate_stream.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/savestate_stream.sv
// rtl/savestate_stream.sv - save-state byte stream engine with 64-bit DDR word buffer
module savestate_stream #(
    parameter int          NUM_CH = 4,
    parameter int          ADDR_W = 20,
    parameter int          SLOT_W = 2,
    parameter logic [31:0] MAGIC  = 32'h4247_4E53
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     save,
    input  logic                     load,
    input  logic [SLOT_W-1:0]        slot,
    input  logic                     save_sd,
    input  logic                     abort,
    input  logic                     byte_stb,
    input  logic [7:0]               byte_wdata,
    output logic [7:0]               byte_rdata,
    output logic                     byte_ready,
    input  logic                     sect_end,
    input  logic                     finish,
    output logic                     busy,
    output logic                     save_en,
    output logic                     load_en,
    output logic                     done,
    output logic                     load_err,
    output logic                     overflow,
    output logic [NUM_CH*ADDR_W-1:0] sect_base,
    output logic [31:0]              ss_count,
    output logic [SLOT_W+ADDR_W-4:0] ddr_addr,
    output logic [63:0]              ddr_do,
    input  logic [63:0]              ddr_di,
    output logic                     ddr_we,
    output logic [7:0]               ddr_be,
    output logic                     ddr_req,
    input  logic                     ddr_ack
);
    localparam int WA_W  = ADDR_W - 3;
    localparam int DA_W  = SLOT_W + WA_W;
    localparam int CNT_W = $clog2(NUM_CH + 1);

    typedef enum logic [3:0] {
        IDLE, HDR_RD, HDR_CHK, XFER, WR_WORD, RD_WORD, FLUSH, WR_HDR, END
    } state_t;

    state_t                   state_q, state_d;
    logic [ADDR_W-1:0]        addr_q, addr_d;
    logic [SLOT_W-1:0]        slot_q, slot_d;
    logic [63:0]              buf_q, buf_d;
    logic                     save_en_q, save_en_d, load_en_q, load_en_d;
    logic                     load_err_q, load_err_d, ovf_q, ovf_d;
    logic [31:0]              ss_cnt_q, ss_cnt_d;
    logic [NUM_CH*ADDR_W-1:0] sect_q, sect_d;
    logic [CNT_W-1:0]         nsect_q, nsect_d;
    logic                     fin_q, fin_d, abt_q, abt_d;
    logic                     req_q, req_d, we_q, we_d;
    logic [7:0]               be_q, be_d;
    logic [63:0]              do_q, do_d;
    logic [DA_W-1:0]          daddr_q, daddr_d;
    logic                     save_prev_q, load_prev_q;

    logic                     iss, iss_we;
    logic [DA_W-1:0]          iss_addr;
    logic [63:0]              iss_do;
    logic [7:0]               iss_be;
    logic [ADDR_W-1:0]        a_n, ns;
    logic [63:0]              b_n, b_m;
    logic                     word_go, part, ack_ok, save_edge, load_edge;

    // header word: {pad, size in 32-bit units, save counter}
    function automatic logic [63:0] hdr_word(input logic [ADDR_W-1:0] sz, input logic [31:0] cnt);
        return {14'd0, 18'(sz[ADDR_W-1:2]), cnt};
    endfunction

    assign ack_ok     = (ddr_ack == req_q);
    assign save_edge  = save & ~save_prev_q;
    assign load_edge  = load & ~load_prev_q;
    assign busy       = (state_q != IDLE);
    assign byte_ready = (state_q == XFER);
    assign done       = (state_q == END);
    assign byte_rdata = buf_q[{addr_q[2:0], 3'b000} +: 8];
    assign save_en    = save_en_q;
    assign load_en    = load_en_q;
    assign load_err   = load_err_q;
    assign overflow   = ovf_q;
    assign sect_base  = sect_q;
    assign ss_count   = ss_cnt_q;
    assign ddr_addr   = daddr_q;
    assign ddr_do     = do_q;
    assign ddr_we     = we_q;
    assign ddr_be     = be_q;
    assign ddr_req    = req_q;

    // next-state, byte datapath and DDR request issue
    always_comb begin
        state_d = state_q;   addr_d = addr_q;       slot_d = slot_q;     buf_d = buf_q;
        save_en_d = save_en_q; load_en_d = load_en_q; load_err_d = 1'b0; ovf_d = ovf_q;
        ss_cnt_d = ss_cnt_q; sect_d = sect_q;       nsect_d = nsect_q;
        fin_d = fin_q;       abt_d = abt_q;
        iss = 1'b0; iss_we = 1'b0; iss_addr = daddr_q; iss_do = do_q; iss_be = be_q;
        a_n = addr_q; ns = addr_q; b_n = buf_q; b_m = buf_q; word_go = 1'b0; part = 1'b0;

        if (state_q != IDLE && (abort || abt_q)) begin
            // let an in-flight transaction finish before dropping to idle
            if (ack_ok) begin
                state_d = IDLE; save_en_d = 1'b0; load_en_d = 1'b0; abt_d = 1'b0;
            end else begin
                abt_d = 1'b1;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (save_edge) begin
                        slot_d = slot; save_en_d = 1'b1; addr_d = ADDR_W'(8);
                        ss_cnt_d = ss_cnt_q + 32'd1; ovf_d = 1'b0; buf_d = 64'd0;
                        nsect_d = '0; fin_d = 1'b0;
                        sect_d = '0; sect_d[ADDR_W-1:0] = ADDR_W'(8);
                        state_d = XFER;
                    end else if (load_edge) begin
                        slot_d = slot; ovf_d = 1'b0; nsect_d = '0; fin_d = 1'b0; sect_d = '0;
                        iss = 1'b1; iss_addr = {slot, WA_W'(1)};
                        state_d = HDR_RD;
                    end
                end
                HDR_RD: if (ack_ok) state_d = HDR_CHK;
                HDR_CHK: begin
                    if (ddr_di[31:0] == MAGIC) begin
                        load_en_d = 1'b1; buf_d = ddr_di; addr_d = ADDR_W'(8);
                        sect_d[ADDR_W-1:0] = ADDR_W'(8);
                        state_d = XFER;
                    end else begin
                        load_err_d = 1'b1;
                        state_d = IDLE;
                    end
                end
                XFER: begin
                    // the byte is applied first, then sect_end / finish see its address
                    if (byte_stb) begin
                        if (&addr_q) begin
                            ovf_d = 1'b1;
                        end else begin
                            a_n = addr_q + ADDR_W'(1);
                            word_go = (addr_q[2:0] == 3'd7);
                            if (save_en_q) begin
                                if (addr_q[2:0] == 3'd0) b_n = 64'd0;
                                b_n[{addr_q[2:0], 3'b000} +: 8] = byte_wdata;
                            end
                        end
                    end
                    part = (a_n[2:0] != 3'd0);
                    ns = a_n;
                    if (sect_end) begin
                        if (part) begin
                            if (&a_n[ADDR_W-1:3]) ovf_d = 1'b1;
                            else ns = {a_n[ADDR_W-1:3] + WA_W'(1), 3'b000};
                        end
                        for (int i = 1; i < NUM_CH; i++)
                            if (i == int'(nsect_q) + 1) sect_d[i*ADDR_W +: ADDR_W] = ns;
                        if (nsect_q != CNT_W'(NUM_CH)) nsect_d = nsect_q + CNT_W'(1);
                    end
                    for (int i = 0; i < 8; i++)
                        if (i >= int'(a_n[2:0])) b_m[i*8 +: 8] = 8'd0;
                    addr_d = ns;
                    buf_d = b_n;
                    if (save_en_q) begin
                        if (word_go) begin
                            iss = 1'b1; iss_we = 1'b1; iss_addr = {slot_q, addr_q[ADDR_W-1:3]};
                            iss_do = b_n; iss_be = 8'hFF; fin_d = finish; state_d = WR_WORD;
                        end else if (part && (sect_end || finish)) begin
                            iss = 1'b1; iss_we = 1'b1; iss_addr = {slot_q, a_n[ADDR_W-1:3]};
                            iss_do = b_m; iss_be = 8'hFF; fin_d = finish; state_d = FLUSH;
                        end else if (finish) begin
                            iss = 1'b1; iss_we = 1'b1; iss_addr = {slot_q, WA_W'(0)};
                            iss_do = hdr_word(ns, ss_cnt_q); iss_be = save_sd ? 8'hFF : 8'hF0;
                            state_d = WR_HDR;
                        end
                    end else begin
                        if (finish) begin
                            state_d = END;
                        end else if (word_go || (sect_end && part)) begin
                            iss = 1'b1; iss_addr = {slot_q, ns[ADDR_W-1:3]};
                            state_d = RD_WORD;
                        end
                    end
                end
                WR_WORD, FLUSH: begin
                    if (ack_ok) begin
                        if (fin_q) begin
                            iss = 1'b1; iss_we = 1'b1; iss_addr = {slot_q, WA_W'(0)};
                            iss_do = hdr_word(addr_q, ss_cnt_q); iss_be = save_sd ? 8'hFF : 8'hF0;
                            state_d = WR_HDR;
                        end else begin
                            state_d = XFER;
                        end
                    end
                end
                RD_WORD: if (ack_ok) begin buf_d = ddr_di; state_d = XFER; end
                WR_HDR:  if (ack_ok) state_d = END;
                END: begin
                    save_en_d = 1'b0; load_en_d = 1'b0; state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        req_d   = iss ? ~req_q : req_q;
        we_d    = iss & iss_we;
        daddr_d = iss ? iss_addr : daddr_q;
        do_d    = iss ? iss_do : do_q;
        be_d    = iss ? iss_be : be_q;
    end

    // state and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;  addr_q <= '0;  slot_q <= '0;  buf_q <= '0;
            save_en_q <= 1'b0; load_en_q <= 1'b0; load_err_q <= 1'b0; ovf_q <= 1'b0;
            ss_cnt_q <= '0;   sect_q <= '0;  nsect_q <= '0; fin_q <= 1'b0; abt_q <= 1'b0;
            req_q <= 1'b0;    we_q <= 1'b0;  be_q <= 8'hFF; do_q <= '0;   daddr_q <= '0;
            save_prev_q <= 1'b0; load_prev_q <= 1'b0;
        end else begin
            state_q <= state_d; addr_q <= addr_d; slot_q <= slot_d; buf_q <= buf_d;
            save_en_q <= save_en_d; load_en_q <= load_en_d; load_err_q <= load_err_d;
            ovf_q <= ovf_d;   ss_cnt_q <= ss_cnt_d; sect_q <= sect_d; nsect_q <= nsect_d;
            fin_q <= fin_d;   abt_q <= abt_d;
            req_q <= req_d;   we_q <= we_d;  be_q <= be_d;  do_q <= do_d;  daddr_q <= daddr_d;
            save_prev_q <= save; load_prev_q <= load;
        end
    end
endmodule

// File: tb/tb_savestate_stream.sv
// tb/tb_savestate_stream.sv - directed bench for savestate_stream
module tb_savestate_stream;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, save, load, save_sd, abort, byte_stb, sect_end, finish;
    logic [1:0]  slot;
    logic [7:0]  byte_wdata, byte_rdata, ddr_be;
    logic        byte_ready, busy, save_en, load_en, done, load_err, overflow;
    logic [79:0] sect_base;
    logic [31:0] ss_count;
    logic [18:0] ddr_addr;
    logic [63:0] ddr_do, ddr_di;
    logic        ddr_we, ddr_req, ddr_ack;

    logic        save4, stb4, fin4, sd4;
    logic [7:0]  wdata4, rdata4, be4;
    logic        rdy4, busy4, sen4, len4, done4, lerr4, ovf4, we4, req4, ack4;
    logic [15:0] sb4;
    logic [31:0] cnt4;
    logic [2:0]  addr4;
    logic [63:0] do4, di4;

    savestate_stream u_dut (
        .clk(clk), .reset_n(reset_n), .save(save), .load(load), .slot(slot),
        .save_sd(save_sd), .abort(abort), .byte_stb(byte_stb), .byte_wdata(byte_wdata),
        .byte_rdata(byte_rdata), .byte_ready(byte_ready), .sect_end(sect_end),
        .finish(finish), .busy(busy), .save_en(save_en), .load_en(load_en), .done(done),
        .load_err(load_err), .overflow(overflow), .sect_base(sect_base), .ss_count(ss_count),
        .ddr_addr(ddr_addr), .ddr_do(ddr_do), .ddr_di(ddr_di), .ddr_we(ddr_we),
        .ddr_be(ddr_be), .ddr_req(ddr_req), .ddr_ack(ddr_ack)
    );

    savestate_stream #(.ADDR_W(4)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .save(save4), .load(1'b0), .slot(2'd0),
        .save_sd(sd4), .abort(1'b0), .byte_stb(stb4), .byte_wdata(wdata4),
        .byte_rdata(rdata4), .byte_ready(rdy4), .sect_end(1'b0),
        .finish(fin4), .busy(busy4), .save_en(sen4), .load_en(len4), .done(done4),
        .load_err(lerr4), .overflow(ovf4), .sect_base(sb4), .ss_count(cnt4),
        .ddr_addr(addr4), .ddr_do(do4), .ddr_di(di4), .ddr_we(we4),
        .ddr_be(be4), .ddr_req(req4), .ddr_ack(ack4)
    );

    int errors = 0;
    int checks = 0;

    logic [63:0] mem [0:15];
    logic [18:0] tx_addr [0:63];
    logic [63:0] tx_do [0:63];
    logic [7:0]  tx_be [0:63];
    logic        tx_we [0:63];
    int          n_tx = 0, we_cnt = 0, ack_delay = 0;
    logic        last_req;
    logic [2:0]  tx4_addr [0:15];
    logic [63:0] tx4_do [0:15];
    logic [7:0]  tx4_be [0:15];
    int          n4 = 0;
    logic        last4;

    // DDR model for the main instance: logs each request, answers after ack_delay cycles
    initial begin
        ddr_ack = 1'b0; ddr_di = 64'd0; last_req = 1'b0;
        forever begin
            @(negedge clk);
            if (ddr_we) we_cnt++;
            if (ddr_req !== last_req) begin
                last_req = ddr_req;
                tx_addr[n_tx] = ddr_addr; tx_do[n_tx] = ddr_do;
                tx_be[n_tx] = ddr_be; tx_we[n_tx] = ddr_we;
                n_tx++;
                if (!ddr_we) ddr_di = mem[ddr_addr[3:0]];
                repeat (ack_delay) begin
                    @(negedge clk);
                    if (ddr_we) we_cnt++;
                end
                ddr_ack = ddr_req;
            end
        end
    end

    // DDR model for the narrow instance: immediate ack
    initial begin
        ack4 = 1'b0; di4 = 64'd0; last4 = 1'b0;
        forever begin
            @(negedge clk);
            if (req4 !== last4) begin
                last4 = req4;
                tx4_addr[n4] = addr4; tx4_do[n4] = do4; tx4_be[n4] = be4;
                n4++;
                ack4 = req4;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (byte_ready !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        check(tag, 64'(byte_ready), 64'h1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        wait_ready("ready_wr");
        byte_stb = 1'b1; byte_wdata = b;
        step();
        byte_stb = 1'b0;
    endtask

    task automatic read_byte(input logic [7:0] exp, input string tag);
        wait_ready("ready_rd");
        check(tag, 64'(byte_rdata), 64'(exp));
        byte_stb = 1'b1;
        step();
        byte_stb = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        logic got = 1'b0;
        while (n < 100 && !got) begin
            if (done === 1'b1) got = 1'b1;
            else begin step(); n++; end
        end
        check(tag, 64'(got), 64'h1);
        step();
        check({tag, "_pulse"}, 64'(done), 64'h0);
        check({tag, "_idle"}, 64'(busy), 64'h0);
    endtask

    initial begin
        int b;
        int cnt;
        reset_n = 1'b0; save = 1'b0; load = 1'b0; slot = 2'd0; save_sd = 1'b0; abort = 1'b0;
        byte_stb = 1'b0; byte_wdata = 8'd0; sect_end = 1'b0; finish = 1'b0;
        save4 = 1'b0; stb4 = 1'b0; fin4 = 1'b0; sd4 = 1'b1; wdata4 = 8'd0;
        for (int i = 0; i < 16; i++) mem[i] = 64'd0;
        repeat (3) step();

        // reset state
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_ready", 64'(byte_ready), 64'h0);
        check("rst_be", 64'(ddr_be), 64'hFF);
        check("rst_req", 64'(ddr_req), 64'h0);
        check("rst_do", ddr_do, 64'h0);
        check("rst_cnt", 64'(ss_count), 64'h0);
        check("rst_sect", 64'(sect_base[63:0]), 64'h0);
        check("rst_ovf", 64'(overflow), 64'h0);
        reset_n = 1'b1;
        step();

        // save 10 bytes, finish with save_sd=1
        save_sd = 1'b1; b = n_tx;
        save = 1'b1; step(); save = 1'b0;
        check("sv_en", 64'(save_en), 64'h1);
        check("sv_cnt", 64'(ss_count), 64'h1);
        for (int i = 1; i <= 10; i++) send_byte(8'(i));
        wait_ready("sv_fin_rdy");
        finish = 1'b1; step(); finish = 1'b0;
        wait_done("sv_done");
        check("sv_ntx", 64'(n_tx - b), 64'h3);
        check("sv_w0_addr", 64'(tx_addr[b]), 64'h1);
        check("sv_w0_do", tx_do[b], 64'h0807060504030201);
        check("sv_w0_we", 64'(tx_we[b]), 64'h1);
        check("sv_w1_addr", 64'(tx_addr[b+1]), 64'h2);
        check("sv_w1_do", tx_do[b+1], 64'h0000000000000A09);
        check("sv_hdr_addr", 64'(tx_addr[b+2]), 64'h0);
        check("sv_hdr_do", tx_do[b+2], 64'h0000000400000001);
        check("sv_hdr_be", 64'(tx_be[b+2]), 64'hFF);
        check("sv_en_clr", 64'(save_en), 64'h0);

        // load from slot 1 with a good magic
        mem[1] = 64'hDEADBEEF42474E53; mem[2] = 64'h1817161514131211;
        b = n_tx; slot = 2'd1;
        load = 1'b1; step(); load = 1'b0; slot = 2'd0;
        wait_ready("ld_rdy");
        check("ld_en", 64'(load_en), 64'h1);
        check("ld_hdr_addr", 64'(tx_addr[b]), 64'h20001);
        check("ld_hdr_we", 64'(tx_we[b]), 64'h0);
        read_byte(8'h53, "ld_b0"); read_byte(8'h4E, "ld_b1");
        read_byte(8'h47, "ld_b2"); read_byte(8'h42, "ld_b3");
        read_byte(8'hEF, "ld_b4"); read_byte(8'hBE, "ld_b5");
        read_byte(8'hAD, "ld_b6"); read_byte(8'hDE, "ld_b7");
        check("ld_fetch_stall", 64'(byte_ready), 64'h0);
        read_byte(8'h11, "ld_b8");
        check("ld_fetch_addr", 64'(tx_addr[b+1]), 64'h20002);
        check("ld_fetch_we", 64'(tx_we[b+1]), 64'h0);
        wait_ready("ld_fin_rdy");
        finish = 1'b1; step(); finish = 1'b0;
        wait_done("ld_done");
        check("ld_ntx", 64'(n_tx - b), 64'h2);
        check("ld_en_clr", 64'(load_en), 64'h0);

        // load with a wrong magic
        mem[1] = 64'h0000000012345678; b = n_tx; cnt = 0;
        load = 1'b1; step(); load = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (load_err === 1'b1) cnt++;
            step();
        end
        check("err_pulse", 64'(cnt), 64'h1);
        check("err_busy", 64'(busy), 64'h0);
        check("err_en", 64'(load_en), 64'h0);
        check("err_ntx", 64'(n_tx - b), 64'h1);

        // sections: 3 bytes, sect_end, 2 bytes, finish with save_sd=0
        save_sd = 1'b0; b = n_tx;
        save = 1'b1; step(); save = 1'b0;
        send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3);
        wait_ready("sec_rdy");
        sect_end = 1'b1; step(); sect_end = 1'b0;
        check("sec_base0", 64'(sect_base[19:0]), 64'h8);
        check("sec_base1", 64'(sect_base[39:20]), 64'h10);
        send_byte(8'hB1); send_byte(8'hB2);
        wait_ready("sec_fin_rdy");
        finish = 1'b1; step(); finish = 1'b0;
        wait_done("sec_done");
        check("sec_ntx", 64'(n_tx - b), 64'h3);
        check("sec_flush_addr", 64'(tx_addr[b]), 64'h1);
        check("sec_flush_do", tx_do[b], 64'h0000000000A3A2A1);
        check("sec_w1_addr", 64'(tx_addr[b+1]), 64'h2);
        check("sec_w1_do", tx_do[b+1], 64'h000000000000B2B1);
        check("sec_hdr_do", tx_do[b+2], 64'h0000000400000002);
        check("sec_hdr_be", 64'(tx_be[b+2]), 64'hF0);

        // simultaneous save+load, then abort during a slow word write
        b = n_tx; cnt = 0; ack_delay = 5;
        save = 1'b1; load = 1'b1; step(); save = 1'b0; load = 1'b0;
        check("both_save", 64'(save_en), 64'h1);
        check("both_noload", 64'(load_en), 64'h0);
        check("both_cnt", 64'(ss_count), 64'h3);
        for (int i = 0; i < 8; i++) send_byte(8'(i + 'h30));
        abort = 1'b1; step(); abort = 1'b0;
        check("abt_wait", 64'(busy), 64'h1);
        for (int i = 0; i < 15; i++) begin
            if (done === 1'b1) cnt++;
            step();
        end
        check("abt_idle", 64'(busy), 64'h0);
        check("abt_nodone", 64'(cnt), 64'h0);
        check("abt_en", 64'(save_en), 64'h0);
        check("abt_ntx", 64'(n_tx - b), 64'h1);
        check("abt_w_do", tx_do[b], 64'h3736353433323130);
        ack_delay = 0;
        check("we_pulses", 64'(we_cnt), 64'h7);

        // narrow address space: overflow at byte 8
        save4 = 1'b1; step(); save4 = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            stb4 = 1'b1; wdata4 = 8'(i);
            step();
            if (i == 7) check("ovf_b7", 64'(ovf4), 64'h0);
            if (i == 8) check("ovf_b8", 64'(ovf4), 64'h1);
        end
        stb4 = 1'b0;
        fin4 = 1'b1; step(); fin4 = 1'b0;
        cnt = 0;
        while (done4 !== 1'b1 && cnt < 50) begin step(); cnt++; end
        check("ovf_done", 64'(done4), 64'h1);
        step();
        check("ovf_ntx", 64'(n4), 64'h2);
        check("ovf_flush_addr", 64'(tx4_addr[0]), 64'h1);
        check("ovf_flush_do", tx4_do[0], 64'h0007060504030201);
        check("ovf_hdr_do", tx4_do[1], 64'h0000000300000001);
        check("ovf_hdr_be", 64'(tx4_be[1]), 64'hFF);
        check("ovf_sticky", 64'(ovf4), 64'h1);
        save4 = 1'b1; step(); save4 = 1'b0;
        check("ovf_clear", 64'(ovf4), 64'h0);
        check("ovf_cnt", 64'(cnt4), 64'h2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
